// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side definitions: FSM states, frame edge indices,
// microsecond-to-cycle conversion and the odd-parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   // Device clock falling edge on which parity / stop are driven.
   localparam logic [3:0] PARITY_EDGE = 4'd9;
   localparam logic [3:0] STOP_EDGE   = 4'd10;

   function automatic int us_to_cyc(input int freq_hz, input int us);
      return freq_hz / 1000000 * us;
   endfunction

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-flop synchronizer, history flop, falling-edge strobe.
// Ports: clk, rst (async high), line_i raw line, line_o synced level,
//        fall_o one-cycle strobe on a synced 1->0 transition.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic line_o,
   output logic fall_o
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], line_i};
      prev_d = sync_q[1];
   end

   // Idle PS/2 lines float high, so reset to 1 to avoid a false fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign line_o = sync_q[1];
   assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device byte sender: inhibit, request-to-send, 8 data
// bits LSB first, odd parity, stop, device ACK; reports done or error.
// Ports: clk, rst (async high); ps2Clk/ps2Data raw lines read back;
//        ps2ClkDriveLow/ps2DataDriveLow open-drain pull-low enables;
//        txStart/txData request; txBusy, txDone, txError, rxInhibit.
// Build option: PS2_TX_RETRY_EN retries once from INHIBIT on failure.
module ps2_host_transmitter
   import ps2_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 100000000,
   parameter int INHIBIT_US      = 120,
   parameter int TIMEOUT_US      = 15000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic       ps2ClkDriveLow,
   output logic       ps2DataDriveLow,
   input  logic       txStart,
   input  logic [7:0] txData,
   output logic       txBusy,
   output logic       txDone,
   output logic       txError,
   output logic       rxInhibit
);

   localparam int INHIBIT_CYC =
      us_to_cyc(CLOCK_FREQUENCY, INHIBIT_US);
   localparam int TIMEOUT_CYC =
      us_to_cyc(CLOCK_FREQUENCY, TIMEOUT_US);
   localparam int MAX_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ?
      TIMEOUT_CYC : INHIBIT_CYC;
   localparam int CNT_W = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       data_q, data_d;
   logic             clk_low_q, clk_low_d;
   logic             dat_low_q, dat_low_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             fail;
   logic             clk_s, clk_fall;
   logic             dat_s, unused_dat_fall;
`ifdef PS2_TX_RETRY_EN
   logic             retry_q, retry_d;
`endif

   ps2_line_sync u_clk_sync (
      .clk    (clk),
      .rst    (rst),
      .line_i (ps2Clk),
      .line_o (clk_s),
      .fall_o (clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .clk    (clk),
      .rst    (rst),
      .line_i (ps2Data),
      .line_o (dat_s),
      .fall_o (unused_dat_fall)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      dat_low_d = dat_low_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q;
`endif
      unique case (state_q)
         IDLE: begin
            dat_low_d = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (txStart) begin
               data_d  = txData;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d     = '0;
               dat_low_d = 1'b1;
               state_d   = RTS;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RTS: begin
            // Start bit stays driven until the first device edge.
            cnt_d     = '0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (clk_fall) begin
               cnt_d     = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_d == STOP_EDGE) begin
                  dat_low_d = 1'b0;
                  state_d   = ACK;
               end else if (bit_cnt_d == PARITY_EDGE) begin
                  dat_low_d = ~odd_parity(data_q);
               end else begin
                  dat_low_d = ~data_q[bit_cnt_q[2:0]];
               end
            end else if (cnt_q == TO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ACK: begin
            if (clk_fall) begin
               cnt_d = '0;
               if (!dat_s) state_d = WAIT_IDLE;
               else        fail    = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAIT_IDLE: begin
            if (clk_fall) begin
               cnt_d = '0;
            end else if (clk_s && dat_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == TO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fail) begin
         dat_low_d = 1'b0;
         cnt_d     = '0;
         bit_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
         if (!retry_q) begin
            retry_d = 1'b1;
            state_d = INHIBIT;
         end else begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
`else
         err_d   = 1'b1;
         state_d = IDLE;
`endif
      end

`ifdef PS2_TX_RETRY_EN
      if (state_d == IDLE) retry_d = 1'b0;
`endif
      clk_low_d = (state_d == INHIBIT) || (state_d == RTS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         clk_low_q <= 1'b0;
         dat_low_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         clk_low_q <= clk_low_d;
         dat_low_q <= dat_low_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign ps2ClkDriveLow  = clk_low_q;
   assign ps2DataDriveLow = dat_low_q;
   assign txBusy          = (state_q != IDLE);
   assign rxInhibit       = txBusy;
   assign txDone          = done_q;
   assign txError         = err_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Scoreboard bench: a keyboard model clocks frames off the wire and
// compares them, a monitor checks done/error pulses against a queue.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;

   localparam int FREQ    = 1000000;
   localparam int INH_US  = 120;
   localparam int TO_US   = 15000;
   localparam int INH_CYC = FREQ / 1000000 * INH_US;
   localparam int TO_CYC  = FREQ / 1000000 * TO_US;
   localparam int CLK_NS  = 10;
   localparam int HALF    = 20;
   localparam int HALF_NS = HALF * CLK_NS;
   localparam int QTR_NS  = HALF_NS / 2;
   localparam int LIMIT   = 3 * TO_CYC + 5000;

   localparam int M_ACK    = 0;
   localparam int M_NACK   = 1;
   localparam int M_SILENT = 2;
   localparam int M_RST    = 3;

   typedef struct {
      int          mode;
      logic [10:0] frame;
   } dev_t;

   typedef struct {
      bit is_err;
      bit chk_to;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2ClkDriveLow, ps2DataDriveLow;
   logic       txStart;
   logic [7:0] txData;
   logic       txBusy, txDone, txError, rxInhibit;
   logic       dclk = 1'b0;
   logic       ddat = 1'b0;
   logic       ps2_clk_w, ps2_data_w;

   assign ps2_clk_w  = ~(ps2ClkDriveLow | dclk);
   assign ps2_data_w = ~(ps2DataDriveLow | ddat);

   dev_t    dev_q[$];
   res_t    res_q[$];
   int      n_chk  = 0;
   int      n_pass = 0;
   longint  cyc    = 0;
   longint  lo_cyc = 0;
   longint  rel_cyc = 0;
   logic    drv_prev = 1'b0;
   bit      rst_hit = 1'b0;

   always #(CLK_NS / 2) clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_host_transmitter #(
      .CLOCK_FREQUENCY (FREQ),
      .INHIBIT_US      (INH_US),
      .TIMEOUT_US      (TO_US)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ps2Clk          (ps2_clk_w),
      .ps2Data         (ps2_data_w),
      .ps2ClkDriveLow  (ps2ClkDriveLow),
      .ps2DataDriveLow (ps2DataDriveLow),
      .txStart         (txStart),
      .txData          (txData),
      .txBusy          (txBusy),
      .txDone          (txDone),
      .txError         (txError),
      .rxInhibit       (rxInhibit)
   );

   task automatic check(input string nm, input longint got,
                        input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
   endtask

   task automatic check_range(input string nm, input longint got,
                              input longint lo, input longint hi);
      n_chk++;
      if (got >= lo && got <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d",
                    nm, got, lo, hi);
   endtask

   // Wire-level frame a correct host must produce: start, data LSB
   // first, odd parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += d[i];
      return {1'b1, (ones % 2 == 0), d, 1'b0};
   endfunction

   // Keyboard model.
   initial begin : device
      dev_t        e;
      logic [10:0] got;
      forever begin
         wait (ps2ClkDriveLow === 1'b1);
         wait (ps2ClkDriveLow === 1'b0);
         check("frame_expected", dev_q.size() > 0, 1);
         if (dev_q.size() > 0) e = dev_q.pop_front();
         else begin
            e.mode  = M_ACK;
            e.frame = '0;
         end
         if (e.mode != M_SILENT) begin
            got = '0;
            #(QTR_NS);
            got[0] = ps2_data_w;
            for (int i = 1; i <= 10; i++) begin
               #(QTR_NS);
               dclk = 1'b1;
               if (e.mode == M_RST && i == 5) begin
                  rst_hit = 1'b1;
                  #(HALF_NS);
                  dclk = 1'b0;
                  break;
               end
               #(HALF_NS);
               dclk = 1'b0;
               #(QTR_NS);
               got[i] = ps2_data_w;
            end
            if (e.mode != M_RST) begin
               check("frame", got, e.frame);
               #(QTR_NS);
               if (e.mode == M_ACK) ddat = 1'b1;
               #(QTR_NS);
               dclk = 1'b1;
               #(HALF_NS);
               dclk = 1'b0;
               #(QTR_NS);
               ddat = 1'b0;
            end
         end
      end
   end

   // Clock-line hold time and release instant.
   always @(negedge clk) begin
      if (rst) begin
         drv_prev <= 1'b0;
      end else begin
         if (ps2ClkDriveLow && !drv_prev) lo_cyc = cyc;
         if (!ps2ClkDriveLow && drv_prev) begin
            rel_cyc = cyc;
            check_range("inhibit_cycles", cyc - lo_cyc,
                        INH_CYC, INH_CYC + 2);
         end
         drv_prev <= ps2ClkDriveLow;
      end
   end

   // Completion monitor.
   always @(negedge clk) begin : monitor
      res_t r;
      if (!rst && (txDone || txError)) begin
         check("result_expected", res_q.size() > 0, 1);
         if (res_q.size() > 0) begin
            r = res_q.pop_front();
            check("done_pulse", txDone, r.is_err ? 0 : 1);
            check("error_pulse", txError, r.is_err ? 1 : 0);
            check("busy_at_end", txBusy, 0);
            check("rx_inhibit_end", rxInhibit, 0);
            if (r.is_err) begin
               check("clk_drive_err", ps2ClkDriveLow, 0);
               check("data_drive_err", ps2DataDriveLow, 0);
            end
            if (r.chk_to)
               check_range("timeout_cycles", cyc - rel_cyc,
                           TO_CYC - 3, TO_CYC + 3);
         end
      end
   end

   task automatic push_dev(input int mode, input logic [7:0] d);
      dev_t e;
      e.mode  = mode;
      e.frame = frame_of(d);
      dev_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d, input int mode);
      res_t r;
      int   n = 0;
      while (txBusy && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("idle_before_send", txBusy, 0);
      push_dev(mode, d);
      if (mode == M_NACK || mode == M_SILENT) begin
`ifdef PS2_TX_RETRY_EN
         push_dev(mode, d);
`endif
         r.is_err = 1'b1;
         r.chk_to = (mode == M_SILENT);
         res_q.push_back(r);
      end else if (mode == M_ACK) begin
         r.is_err = 1'b0;
         r.chk_to = 1'b0;
         res_q.push_back(r);
      end
      @(negedge clk);
      txData  = d;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      check("busy_after_start", txBusy, 1);
      check("rx_inhibit_busy", rxInhibit, 1);
   endtask

   task automatic wait_quiet();
      int n = 0;
      while (!(res_q.size() == 0 && dev_q.size() == 0 && !txBusy)
             && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("transaction_finished", n < LIMIT, 1);
      repeat (2 * HALF) @(negedge clk);
   endtask

   initial begin : stim
      int mode;
      int n;
      rst     = 1'b1;
      txStart = 1'b0;
      txData  = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_clk_drive", ps2ClkDriveLow, 0);
      check("rst_data_drive", ps2DataDriveLow, 0);
      check("rst_busy", txBusy, 0);
      check("rst_done", txDone, 0);
      check("rst_error", txError, 0);
      check("rst_rx_inhibit", rxInhibit, 0);

      send(8'hED, M_ACK);
      wait_quiet();
      send(8'h01, M_ACK);
      wait_quiet();
      send(8'h3C, M_NACK);
      wait_quiet();
      send(8'hA7, M_SILENT);
      wait_quiet();

      send(8'hC3, M_RST);
      n = 0;
      while (!rst_hit && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("rst_point_reached", rst_hit, 1);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_clk_drive", ps2ClkDriveLow, 0);
      check("midrst_data_drive", ps2DataDriveLow, 0);
      check("midrst_busy", txBusy, 0);
      check("midrst_done", txDone, 0);
      check("midrst_error", txError, 0);
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      rst_hit = 1'b0;
      repeat (3 * HALF) @(negedge clk);
      send(8'h5A, M_ACK);
      wait_quiet();

      send(8'hFF, M_ACK);
      repeat (200) @(negedge clk);
      check("busy_mid_frame", txBusy, 1);
      txData  = 8'h55;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      wait_quiet();

      for (int i = 0; i < 8; i++) begin
         mode = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
         send(8'($urandom_range(0, 255)), mode);
         wait_quiet();
      end

      repeat (300) @(negedge clk);
      check("frames_left", dev_q.size(), 0);
      check("results_left", res_q.size(), 0);
      check("busy_final", txBusy, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
